// File: rtl/sipo_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sipo_frame_ctrl
//
// Framed serial-in / parallel-out capture controller. A start strobe arms
// capture; each bit_en strobe shifts one serial bit into an internal shift
// register. When WIDTH bits have been captured, the word moves into a held
// output register that is offered to the consumer on a valid/ready
// handshake. Because the output is double-buffered against the shift
// register, the next frame can shift in while the previous word waits.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: first received bit ends up in po[WIDTH-1]
//              0: first received bit ends up in po[0]
//
// Ports
//   clk       in   system clock, rising edge
//   clear     in   synchronous active-high reset
//   start     in   frame start strobe (arms, or aborts and restarts)
//   si        in   serial data bit, used only with bit_en in SHIFT
//   bit_en    in   one bit is taken per cycle this is high
//   po_ready  in   consumer accepts po while po_valid is high
//   po        out  held parallel word
//   po_valid  out  po holds a word not yet accepted
//   busy      out  a frame capture is in progress
//   overrun   out  sticky: a completed word had nowhere to go
//   bit_cnt   out  number of bits captured in the current frame
// ---------------------------------------------------------------------------
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       si,
    input  logic                       bit_en,
    input  logic                       po_ready,
    output logic [WIDTH-1:0]           po,
    output logic                       po_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Index of the last bit of a frame; the edge that takes this bit
    // completes the word.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Registered state
    state_t             state_r;
    logic [WIDTH-1:0]   sr_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [WIDTH-1:0]   po_r;
    logic               po_valid_r;
    logic               overrun_r;
    logic               busy_r;

    // Next-state values
    state_t             state_s;
    logic [WIDTH-1:0]   sr_s;
    logic [CNT_W-1:0]   bit_cnt_s;
    logic [WIDTH-1:0]   po_s;
    logic               po_valid_s;
    logic               overrun_s;

    // Helper terms
    logic [WIDTH-1:0]   shifted_s;
    logic               transfer_s;
    logic               last_bit_s;
    logic               can_load_s;

    // Shift register contents after taking the current si, in the chosen order.
    always_comb begin
        shifted_s = sr_r;
        if (MSB_FIRST != 0) begin
            shifted_s = {sr_r[WIDTH-2:0], si};
        end else begin
            shifted_s = {si, sr_r[WIDTH-1:1]};
        end
    end

    // Handshake and completion qualifiers.
    always_comb begin
        transfer_s = po_valid_r & po_ready;
        last_bit_s = (bit_cnt_r == LAST_IDX);
        // The holding register is free if empty or being emptied this edge.
        can_load_s = (~po_valid_r) | po_ready;
    end

    // Next-state and datapath update for frame capture and the output holder.
    always_comb begin
        state_s    = state_r;
        sr_s       = sr_r;
        bit_cnt_s  = bit_cnt_r;
        po_s       = po_r;
        po_valid_s = po_valid_r;
        overrun_s  = overrun_r;

        // A transfer empties the holder unless a completion refills it below.
        if (transfer_s) begin
            po_valid_s = 1'b0;
        end else begin
            po_valid_s = po_valid_r;
        end

        case (state_r)
            IDLE: begin
                // bit_en/si are ignored here; a bit coincident with start is
                // not captured.
                if (start) begin
                    state_s   = SHIFT;
                    sr_s      = '0;
                    bit_cnt_s = '0;
                end else begin
                    state_s   = IDLE;
                end
            end

            SHIFT: begin
                if (start) begin
                    // Abort and restart; beats bit_en, including on what
                    // would have been the completing bit.
                    state_s   = SHIFT;
                    sr_s      = '0;
                    bit_cnt_s = '0;
                end else if (bit_en) begin
                    sr_s = shifted_s;
                    if (last_bit_s) begin
                        state_s   = IDLE;
                        bit_cnt_s = '0;
                        if (can_load_s) begin
                            po_s       = shifted_s;
                            po_valid_s = 1'b1;
                        end else begin
                            // Holder still occupied: drop the word.
                            overrun_s = 1'b1;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    end
                end else begin
                    // No strobe: hold position, no timeout.
                    state_s = SHIFT;
                end
            end

            default: begin
                state_s   = IDLE;
                sr_s      = '0;
                bit_cnt_s = '0;
            end
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r    <= IDLE;
            sr_r       <= '0;
            bit_cnt_r  <= '0;
            po_r       <= '0;
            po_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            sr_r       <= sr_s;
            bit_cnt_r  <= bit_cnt_s;
            po_r       <= po_s;
            po_valid_r <= po_valid_s;
            overrun_r  <= overrun_s;
            busy_r     <= (state_s == SHIFT);
        end
    end

    assign po       = po_r;
    assign po_valid = po_valid_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;
    assign bit_cnt  = bit_cnt_r;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic clear, start, si, bit_en, po_ready;

    logic [W-1:0] po_m, po_l;
    logic         valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
    logic [2:0]   cnt_m, cnt_l;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is a list of received bits
    bit         m_busy, m_valid, m_ovr;
    logic [W-1:0] m_po_msb, m_po_lsb;
    bit         m_bits[$];

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .clear(clear), .start(start), .si(si), .bit_en(bit_en),
        .po_ready(po_ready), .po(po_m), .po_valid(valid_m), .busy(busy_m),
        .overrun(ovr_m), .bit_cnt(cnt_m)
    );

    sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .clear(clear), .start(start), .si(si), .bit_en(bit_en),
        .po_ready(po_ready), .po(po_l), .po_valid(valid_l), .busy(busy_l),
        .overrun(ovr_l), .bit_cnt(cnt_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Word assembled from the received bit list in either order.
    function automatic logic [W-1:0] word_of(input bit msb_first);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb_first) w[W-1-i] = m_bits[i];
            else           w[i]     = m_bits[i];
        end
        return w;
    endfunction

    task automatic model_update(input bit st, input bit s, input bit be,
                                input bit rdy, input bit clr);
        bit accept, done;
        if (clr) begin
            m_busy = 0; m_valid = 0; m_ovr = 0;
            m_po_msb = '0; m_po_lsb = '0;
            m_bits.delete();
            return;
        end
        accept = !m_valid || rdy;
        done   = m_busy && !st && be && (m_bits.size() == W - 1);
        if (m_valid && rdy) m_valid = 0;
        if (done) begin
            m_bits.push_back(s);
            if (accept) begin
                m_po_msb = word_of(1'b1);
                m_po_lsb = word_of(1'b0);
                m_valid  = 1;
            end else begin
                m_ovr = 1;
            end
            m_bits.delete();
            m_busy = 0;
        end else if (st) begin
            m_bits.delete();
            m_busy = 1;
        end else if (m_busy && be) begin
            m_bits.push_back(s);
        end
    endtask

    task automatic compare_all();
        check("po_msb",   32'(po_m),    32'(m_po_msb));
        check("po_lsb",   32'(po_l),    32'(m_po_lsb));
        check("valid_m",  32'(valid_m), 32'(m_valid));
        check("valid_l",  32'(valid_l), 32'(m_valid));
        check("busy_m",   32'(busy_m),  32'(m_busy));
        check("busy_l",   32'(busy_l),  32'(m_busy));
        check("ovr_m",    32'(ovr_m),   32'(m_ovr));
        check("ovr_l",    32'(ovr_l),   32'(m_ovr));
        check("cnt_m",    32'(cnt_m),   32'(m_bits.size()));
        check("cnt_l",    32'(cnt_l),   32'(m_bits.size()));
    endtask

    task automatic step(input bit st, input bit s, input bit be,
                        input bit rdy, input bit clr);
        start = st; si = s; bit_en = be; po_ready = rdy; clear = clr;
        @(posedge clk);
        model_update(st, s, be, rdy, clr);
        #1;
        compare_all();
    endtask

    // Shift a full word (first bit is w[3]) on consecutive cycles, ready held low.
    task automatic shift_word(input logic [3:0] w);
        step(1, 0, 0, 0, 0);
        for (int i = W - 1; i >= 0; i--) step(0, w[i], 1, 0, 0);
    endtask

    initial begin
        start = 0; si = 0; bit_en = 0; po_ready = 0; clear = 1;

        // 1: clear mid-activity
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        check("t1_po",    32'(po_m),    32'h0);
        check("t1_valid", 32'(valid_m), 32'h0);
        check("t1_busy",  32'(busy_m),  32'h0);
        check("t1_cnt",   32'(cnt_m),   32'h0);
        step(0, 0, 0, 0, 1);

        // 2: basic frame 1011
        step(1, 0, 0, 0, 0);
        check("t2_busy0", 32'(busy_m), 32'h1);
        check("t2_cnt0",  32'(cnt_m),  32'h0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        check("t2_cnt3", 32'(cnt_m), 32'h3);
        step(0, 1, 1, 0, 0);
        check("t2_po",    32'(po_m),    32'hB);
        check("t2_valid", 32'(valid_m), 32'h1);
        check("t2_busy",  32'(busy_m),  32'h0);
        step(0, 0, 0, 1, 0);
        check("t2_drain", 32'(valid_m), 32'h0);

        // 3: sparse strobes, si toggling on idle cycles
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("t3_po", 32'(po_m), 32'hC);
        step(0, 0, 0, 1, 0);

        // 4: overrun and recovery
        shift_word(4'b1011);
        shift_word(4'b0110);
        check("t4_po",    32'(po_m),    32'hB);
        check("t4_valid", 32'(valid_m), 32'h1);
        check("t4_ovr",   32'(ovr_m),   32'h1);
        step(0, 0, 0, 1, 0);
        check("t4_valid2", 32'(valid_m), 32'h0);
        check("t4_ovr2",   32'(ovr_m),   32'h1);

        // 5: transfer and completion on the same edge
        step(0, 0, 0, 0, 1);
        shift_word(4'b1011);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        check("t5_po",    32'(po_m),    32'h5);
        check("t5_valid", 32'(valid_m), 32'h1);
        check("t5_ovr",   32'(ovr_m),   32'h0);
        step(0, 0, 0, 1, 0);

        // 6: abort/restart, LSB-first ordering, clear mid-frame
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        check("t6_restart_cnt", 32'(cnt_m), 32'h0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        check("t6_po", 32'(po_m), 32'h3);
        step(0, 0, 0, 1, 0);
        shift_word(4'b1000);
        check("t6_lsb_po", 32'(po_l), 32'h1);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        check("t6_idle_busy", 32'(busy_m), 32'h0);
        check("t6_idle_cnt",  32'(cnt_m),  32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(15) == 0), bit'($urandom_range(1)),
                 bit'($urandom_range(3) != 0), bit'($urandom_range(2) == 0),
                 bit'($urandom_range(149) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
